// File: rtl/seq_lut_pkg.sv
// Shared types and constants for the sequencer LUT loader.
// Optional readback verification is enabled with the LUT_VERIFY_EN macro.
package seq_lut_pkg;

  localparam int unsigned LUT_DEPTH = 256;
  localparam int unsigned WR_W      = 37;
  localparam int unsigned RD_W      = 29;
  localparam int unsigned CNT_W     = 9;

  // Field layout of one sequencer LUT word.
  localparam int unsigned NEXT_STATE_LSB = 0;
  localparam int unsigned NEXT_STATE_MSB = 2;
  localparam int unsigned REPEAT_LSB     = 3;
  localparam int unsigned REPEAT_MSB     = 10;
  localparam int unsigned LENGTH_LSB     = 11;
  localparam int unsigned LENGTH_MSB     = 26;
  localparam int unsigned EOF_BIT        = 27;
  localparam int unsigned SOF_BIT        = 28;
  localparam int unsigned NEXT_ADDR_LSB  = 29;
  localparam int unsigned NEXT_ADDR_MSB  = 36;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StWrite,
    StRbClr,
    StRead,
    StCheck,
    StRun,
    StErr
  } state_e;

endpackage

// File: rtl/seq_lut_loader_if.sv
// Host word stream into the LUT loader: valid/data from host, ready from loader.
// Used unchanged whether or not LUT_VERIFY_EN is defined.
interface seq_lut_loader_if #(
  parameter int unsigned WR_W = seq_lut_pkg::WR_W
) ();

  logic            host_valid;
  logic [WR_W-1:0] host_data;
  logic            host_ready;

  modport master (
    output host_valid,
    output host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid,
    input  host_data,
    output host_ready
  );

endinterface

// File: rtl/seq_lut_csum.sv
// Clearable RD_W-bit modular accumulator; two instances compare write and
// readback sums when LUT_VERIFY_EN is defined.
module seq_lut_csum #(
  parameter int unsigned RD_W = seq_lut_pkg::RD_W
) (
  input  logic            clk,
  input  logic            reset_i,
  input  logic            clr_i,
  input  logic            add_i,
  input  logic [RD_W-1:0] data_i,
  output logic [RD_W-1:0] sum_o
);

  logic [RD_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset_i || clr_i) begin
      sum_q <= '0;
    end else if (add_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/seq_lut_loader.sv
// Loads host words into the sequencer LUT and releases the sequencer when done.
// Define LUT_VERIFY_EN to add a readback pass whose sum must match the written sum.
module seq_lut_loader #(
  parameter int unsigned LUT_DEPTH = seq_lut_pkg::LUT_DEPTH,
  parameter int unsigned WR_W      = seq_lut_pkg::WR_W,
  parameter int unsigned RD_W      = seq_lut_pkg::RD_W
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [8:0]            num_entries_i,
  seq_lut_loader_if.slave       host,
  output logic                  seq_reset_o,
  output logic                  lut_wen_o,
  output logic [WR_W-1:0]       lut_write_data_o,
  output logic                  lut_rden_o,
  input  logic [RD_W-1:0]       lut_read_data_i,
  output logic                  config_done_o,
  output logic                  busy_o,
  output logic                  error_o,
  output logic [8:0]            entry_count_o
);

  import seq_lut_pkg::*;

  state_e     state_q, state_d;
  logic [8:0] num_q, num_d;
  logic [8:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  // Set when CLR is the abort pulse rather than the start of a load.
  logic       abort_q, abort_d;
  logic       start_ok;
  logic       wr_fire;

  assign start_ok = (num_entries_i != '0) && (32'(num_entries_i) <= LUT_DEPTH);
  assign wr_fire  = lut_wen_o;

`ifdef LUT_VERIFY_EN
  logic [8:0]      rd_cnt_q, rd_cnt_d;
  logic            rden_q;
  logic            wsum_clr, rsum_clr;
  logic [RD_W-1:0] wr_sum, rd_sum;

  seq_lut_csum #(.RD_W(RD_W)) u_wr_sum (
    .clk     (clk),
    .reset_i (reset_i),
    .clr_i   (wsum_clr),
    .add_i   (wr_fire),
    .data_i  (host.host_data[RD_W-1:0]),
    .sum_o   (wr_sum)
  );

  seq_lut_csum #(.RD_W(RD_W)) u_rd_sum (
    .clk     (clk),
    .reset_i (reset_i),
    .clr_i   (rsum_clr),
    .add_i   (rden_q),
    .data_i  (lut_read_data_i),
    .sum_o   (rd_sum)
  );
`else
  logic unused_rd_data;
  assign unused_rd_data = ^lut_read_data_i;
`endif

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    abort_d = abort_q;
`ifdef LUT_VERIFY_EN
    rd_cnt_d = rd_cnt_q;
    wsum_clr = 1'b0;
    rsum_clr = 1'b0;
`endif
    if (abort_i && (state_q != StIdle)) begin
      state_d = StClr;
      abort_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StRun, StErr: begin
          if (start_i) begin
            if (start_ok) begin
              num_d   = num_entries_i;
              cnt_d   = '0;
              err_d   = 1'b0;
              abort_d = 1'b0;
              state_d = StClr;
`ifdef LUT_VERIFY_EN
              wsum_clr = 1'b1;
`endif
            end else begin
              err_d   = 1'b1;
              state_d = StErr;
            end
          end
        end
        StClr: begin
          abort_d = 1'b0;
          state_d = abort_q ? StIdle : StWrite;
        end
        StWrite: begin
          if (wr_fire) begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q + 9'd1 == num_q) begin
`ifdef LUT_VERIFY_EN
              state_d = StRbClr;
`else
              state_d = StRun;
`endif
            end
          end
        end
`ifdef LUT_VERIFY_EN
        StRbClr: begin
          rd_cnt_d = '0;
          rsum_clr = 1'b1;
          state_d  = StRead;
        end
        StRead: begin
          rd_cnt_d = rd_cnt_q + 9'd1;
          if (rd_cnt_q + 9'd1 == num_q) state_d = StCheck;
        end
        StCheck: begin
          // The final readback word lands one cycle after the last strobe.
          if (!rden_q) begin
            if (rd_sum == wr_sum) begin
              state_d = StRun;
            end else begin
              err_d   = 1'b1;
              state_d = StErr;
            end
          end
        end
`else
        StRbClr, StRead, StCheck: state_d = StIdle;
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= StIdle;
      num_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

`ifdef LUT_VERIFY_EN
  always_ff @(posedge clk) begin
    if (reset_i) begin
      rd_cnt_q <= '0;
      rden_q   <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      rden_q   <= lut_rden_o;
    end
  end

  assign lut_rden_o = !reset_i && (state_q == StRead);
`else
  assign lut_rden_o = 1'b0;
`endif

  assign seq_reset_o      = reset_i || (state_q == StClr) || (state_q == StRbClr);
  assign host.host_ready  = !reset_i && (state_q == StWrite);
  assign lut_wen_o        = host.host_ready && host.host_valid;
  assign lut_write_data_o = lut_wen_o ? host.host_data : '0;
  assign config_done_o    = !reset_i && (state_q == StRun);
  assign busy_o           = !reset_i && !(state_q inside {StIdle, StRun, StErr});
  assign error_o          = !reset_i && err_q;
  assign entry_count_o    = reset_i ? '0 : cnt_q;

endmodule

// File: tb/tb_seq_lut_loader.sv
// Self-checking bench for seq_lut_loader with a simple sequencer LUT model.
// Verification scenarios run only when LUT_VERIFY_EN is defined.
module tb_seq_lut_loader;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [8:0]  num_entries_i = '0;
  logic        seq_reset_o, lut_wen_o, lut_rden_o;
  logic [36:0] lut_write_data_o;
  logic [28:0] lut_read_data_i;
  logic        config_done_o, busy_o, error_o;
  logic [8:0]  entry_count_o;

  int vectors = 0;
  int miscompares = 0;

  seq_lut_loader_if #(.WR_W(37)) host_bus ();

  seq_lut_loader dut (
    .clk              (clk),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .num_entries_i    (num_entries_i),
    .host             (host_bus),
    .seq_reset_o      (seq_reset_o),
    .lut_wen_o        (lut_wen_o),
    .lut_write_data_o (lut_write_data_o),
    .lut_rden_o       (lut_rden_o),
    .lut_read_data_i  (lut_read_data_i),
    .config_done_o    (config_done_o),
    .busy_o           (busy_o),
    .error_o          (error_o),
    .entry_count_o    (entry_count_o)
  );

  always #5 clk = ~clk;

  // Sequencer model: one address pointer cleared by seq_reset_o.
  logic [36:0] mem [0:255];
  logic [7:0]  ptr = '0;
  logic [28:0] rd_data = '0;
  logic        corrupt = 1'b0;
  int          cyc = 0;

  assign lut_read_data_i = rd_data;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (seq_reset_o) begin
      ptr <= '0;
    end else if (lut_wen_o) begin
      mem[ptr] <= lut_write_data_o;
      ptr <= ptr + 8'd1;
    end else if (lut_rden_o) begin
      rd_data <= mem[ptr][28:0] ^ {28'b0, (corrupt && ptr == 8'd1)};
      ptr <= ptr + 8'd1;
    end
  end

  // Scoreboard and strobe monitor.
  logic [36:0] exp_q [$];
  int          wen_stamp [$];
  int          wen_cnt = 0;
  int          rden_cnt = 0;
  int          srst_cnt = 0;

  always @(negedge clk) begin
    if (lut_wen_o) begin
      wen_cnt++;
      wen_stamp.push_back(cyc);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wen_unexpected: data %h, required no write", lut_write_data_o);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if (lut_write_data_o !== e) begin
          miscompares++;
          $display("FAIL wdata: got %h, required %h", lut_write_data_o, e);
        end
      end
    end else if (lut_write_data_o !== '0) begin
      vectors++;
      miscompares++;
      $display("FAIL wdata_idle: got %h, required 0", lut_write_data_o);
    end
    if (lut_rden_o) rden_cnt++;
    if (seq_reset_o && !reset_i) srst_cnt++;
  end

  task automatic do_start(input logic [8:0] n);
    start_i = 1'b1;
    num_entries_i = n;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_word(input logic [36:0] w, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    host_bus.host_valid = 1'b1;
    host_bus.host_data = w;
    exp_q.push_back(w);
    t = 0;
    forever begin
      @(negedge clk);
      if (host_bus.host_ready) break;
      t++;
      if (t > 100) begin
        vectors++;
        miscompares++;
        $display("FAIL ready_timeout: host_ready 0, required 1 within 100 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    host_bus.host_valid = 1'b0;
    host_bus.host_data = '0;
  endtask

  task automatic wait_settled(input string tag);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (config_done_o || error_o) break;
      t++;
      if (t > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_timeout: neither done nor error within 200 cycles", tag);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if ({seq_reset_o, lut_wen_o, lut_rden_o, config_done_o, busy_o, error_o,
         host_bus.host_ready, entry_count_o} !== {1'b1, 6'b0, 9'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: srst=%b wen=%b rden=%b done=%b busy=%b err=%b rdy=%b cnt=%0d, required srst=1 rest 0",
               seq_reset_o, lut_wen_o, lut_rden_o, config_done_o, busy_o, error_o,
               host_bus.host_ready, entry_count_o);
    end
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({seq_reset_o, config_done_o, busy_o, error_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_outputs: srst=%b done=%b busy=%b err=%b, required all 0",
               seq_reset_o, config_done_o, busy_o, error_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int w0;
    wen_stamp.delete();
    w0 = wen_cnt;
    do_start(9'd3);
    send_word(37'h1_0000_0001, 0);
    send_word(37'h2, 0);
    send_word(37'h3, 0);
    wait_settled("b2b");
    vectors++;
    if (wen_cnt - w0 != 3) begin
      miscompares++;
      $display("FAIL b2b_wen_count: got %0d, required 3", wen_cnt - w0);
    end
    vectors++;
    if (wen_stamp.size() != 3 || wen_stamp[1] != wen_stamp[0] + 1 ||
        wen_stamp[2] != wen_stamp[1] + 1) begin
      miscompares++;
      $display("FAIL b2b_consecutive: %0d stamps, required 3 on consecutive cycles",
               wen_stamp.size());
    end
    vectors++;
    if (config_done_o !== 1'b1 || entry_count_o !== 9'd3 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done: done=%b cnt=%0d busy=%b, required done=1 cnt=3 busy=0",
               config_done_o, entry_count_o, busy_o);
    end
  endtask

  task automatic test_gap;
    wen_stamp.delete();
    // Started from RUN: restart must drop config_done_o.
    do_start(9'd2);
    vectors++;
    if (config_done_o !== 1'b0 || entry_count_o !== 9'd0) begin
      miscompares++;
      $display("FAIL restart: done=%b cnt=%0d, required done=0 cnt=0",
               config_done_o, entry_count_o);
    end
    send_word(37'h0_1234_5678, 0);
    send_word(37'h1F_0000_00AB, 4);
    wait_settled("gap");
    vectors++;
    if (wen_stamp.size() != 2 || wen_stamp[1] - wen_stamp[0] != 5) begin
      miscompares++;
      $display("FAIL gap_spacing: %0d pulses, required 2 pulses 5 cycles apart",
               wen_stamp.size());
    end
    vectors++;
    if (config_done_o !== 1'b1 || entry_count_o !== 9'd2) begin
      miscompares++;
      $display("FAIL gap_done: done=%b cnt=%0d, required done=1 cnt=2",
               config_done_o, entry_count_o);
    end
  endtask

  task automatic test_bad_count;
    int w0, r0;
    w0 = wen_cnt;
    r0 = rden_cnt;
    do_start(9'd0);
    @(negedge clk);
    vectors++;
    if (error_o !== 1'b1 || busy_o !== 1'b0 || config_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL count0: err=%b busy=%b done=%b, required err=1 busy=0 done=0",
               error_o, busy_o, config_done_o);
    end
    @(posedge clk); #1;
    do_start(9'd257);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (error_o !== 1'b1 || busy_o !== 1'b0 || config_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL count257: err=%b busy=%b done=%b, required err=1 busy=0 done=0",
               error_o, busy_o, config_done_o);
    end
    vectors++;
    if (wen_cnt != w0 || rden_cnt != r0) begin
      miscompares++;
      $display("FAIL bad_count_access: wen %0d rden %0d, required 0 0",
               wen_cnt - w0, rden_cnt - r0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int s0;
    // Legal start out of ERR clears the sticky error.
    do_start(9'd10);
    vectors++;
    if (error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: err=%b, required 0", error_o);
    end
    for (int i = 0; i < 5; i++) send_word(37'(64'h100 + i), 0);
    s0 = srst_cnt;
    abort_i = 1'b1;
    start_i = 1'b1;
    num_entries_i = 9'd4;
    @(posedge clk); #1;
    abort_i = 1'b0;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (srst_cnt - s0 != 1) begin
      miscompares++;
      $display("FAIL abort_pulse: seq_reset cycles %0d, required 1", srst_cnt - s0);
    end
    vectors++;
    if (config_done_o !== 1'b0 || busy_o !== 1'b0 || entry_count_o !== 9'd5) begin
      miscompares++;
      $display("FAIL abort_idle: done=%b busy=%b cnt=%0d, required 0 0 5",
               config_done_o, busy_o, entry_count_o);
    end
    @(posedge clk); #1;
    do_start(9'd10);
    for (int i = 0; i < 10; i++) send_word(37'(64'h2_0000_0000 + 3 * i), 0);
    wait_settled("reload");
    vectors++;
    if (config_done_o !== 1'b1 || entry_count_o !== 9'd10 || error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reload: done=%b cnt=%0d err=%b, required 1 10 0",
               config_done_o, entry_count_o, error_o);
    end
  endtask

`ifdef LUT_VERIFY_EN
  task automatic test_verify;
    corrupt = 1'b1;
    do_start(9'd3);
    send_word(37'h1_0000_0001, 0);
    send_word(37'h2, 0);
    send_word(37'h3, 0);
    wait_settled("verify_bad");
    vectors++;
    if (error_o !== 1'b1 || config_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL verify_corrupt: err=%b done=%b, required 1 0", error_o, config_done_o);
    end
    corrupt = 1'b0;
    do_start(9'd3);
    send_word(37'h1_0000_0001, 0);
    send_word(37'h2, 0);
    send_word(37'h3, 0);
    wait_settled("verify_good");
    vectors++;
    if (error_o !== 1'b0 || config_done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL verify_clean: err=%b done=%b, required 0 1", error_o, config_done_o);
    end
  endtask

  task automatic test_reset_mid;
    int t, r0;
    do_start(9'd8);
    for (int i = 0; i < 8; i++) send_word(37'(64'h11 * (i + 1)), 0);
    t = 0;
    forever begin
      @(negedge clk);
      if (lut_rden_o) break;
      t++;
      if (t > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL read_timeout: no rden within 50 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({seq_reset_o, lut_wen_o, lut_rden_o, config_done_o, busy_o, error_o,
         entry_count_o} !== {1'b1, 5'b0, 9'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: srst=%b wen=%b rden=%b done=%b busy=%b err=%b cnt=%0d, required srst=1 rest 0",
               seq_reset_o, lut_wen_o, lut_rden_o, config_done_o, busy_o, error_o,
               entry_count_o);
    end
    @(posedge clk); #1;
    reset_i = 1'b0;
    r0 = rden_cnt;
    repeat (12) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (rden_cnt != r0 || busy_o !== 1'b0 || config_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_after: extra rden %0d busy=%b done=%b, required 0 0 0",
               rden_cnt - r0, busy_o, config_done_o);
    end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_reset_mid;
    int w0;
    do_start(9'd4);
    send_word(37'hA, 0);
    send_word(37'hB, 0);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    w0 = wen_cnt;
    host_bus.host_valid = 1'b1;
    host_bus.host_data = 37'hC;
    repeat (6) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (wen_cnt != w0 || busy_o !== 1'b0 || entry_count_o !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_mid: extra wen %0d busy=%b cnt=%0d, required 0 0 0",
               wen_cnt - w0, busy_o, entry_count_o);
    end
    @(posedge clk); #1;
    host_bus.host_valid = 1'b0;
    host_bus.host_data = '0;
  endtask
`endif

  initial begin
    host_bus.host_valid = 1'b0;
    host_bus.host_data = '0;
    #1;
    test_reset;
    test_back_to_back;
    test_gap;
    test_bad_count;
    test_abort;
`ifdef LUT_VERIFY_EN
    test_verify;
`endif
    test_reset_mid;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d words never written, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
